// File: rtl/boot_pkg.sv
// Boot download protocol constants shared by the host-side loader
// and the target-side boot block.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_FETCH,
        ST_SEND,
        ST_STAT,
        ST_TERM,
        ST_FIN,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0]  MODE_WR_BYTE = 8'h02;
    localparam logic [7:0]  MODE_RD_BYTE = 8'h03;
    localparam logic [31:0] END_MARKER   = 32'hFFFF_FFFF;
    localparam logic [7:0]  DUMMY_BYTE   = 8'h00;
    localparam logic [7:0]  TERM_BYTE    = 8'hFF;

    function automatic logic [7:0] word_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One SPI byte exchange: hold the request until ack, then enforce
// an idle gap so the target can service its byte interrupt.
module spi_byte_xfer #(
    parameter int GAP_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx,
    output logic       ready,
    output logic [7:0] rx,
    output logic       ack,
    output logic       o_spi_req,
    output logic [7:0] o_spi_tx,
    input  logic       i_spi_ack,
    input  logic [7:0] i_spi_rx
);

    localparam int CW = $clog2(GAP_CYC + 2);

    logic [CW-1:0] gap_cnt;

    assign ack   = o_spi_req & i_spi_ack;
    assign ready = !o_spi_req && (gap_cnt == '0);
    assign rx    = i_spi_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_spi_req <= 1'b0;
            o_spi_tx  <= 8'h00;
            gap_cnt   <= '0;
        end else if (ack) begin
            o_spi_req <= 1'b0;
            gap_cnt   <= CW'(GAP_CYC);
        end else if (go && ready) begin
            o_spi_req <= 1'b1;
            o_spi_tx  <= tx;
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/boot_loader_tx.sv
// Host-side boot loader: streams program words from a source memory
// to the target over SPI, checking the per-word status echo.
module boot_loader_tx
    import boot_pkg::*;
#(
    parameter int          GAP_CYC  = 16,
    parameter logic [7:0]  MODE_WR  = MODE_WR_BYTE,
    parameter logic [31:0] BASE_ADR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] n_words,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        o_mem_cyc,
    output logic [31:0] o_mem_adr,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    output logic        o_spi_req,
    output logic [7:0]  o_spi_tx,
    input  logic        i_spi_ack,
    input  logic [7:0]  i_spi_rx
);

    boot_state_e state, state_nx;

    logic [15:0] wi, nw;
    logic [31:0] word;
    logic [1:0]  bc;
    logic        go, ready, x_ack;
    logic [7:0]  tx, rx;
    logic        mem_ack, last_byte, stat_ok, word_bad;

    assign mem_ack   = o_mem_cyc & i_mem_ack;
    assign last_byte = (bc == 2'd3);
    assign stat_ok   = (rx == wi[7:0]);
    assign word_bad  = (i_mem_dat == END_MARKER);

    spi_byte_xfer #(
        .GAP_CYC (GAP_CYC)
    ) u_xfer (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .tx        (tx),
        .ready     (ready),
        .rx        (rx),
        .ack       (x_ack),
        .o_spi_req (o_spi_req),
        .o_spi_tx  (o_spi_tx),
        .i_spi_ack (i_spi_ack),
        .i_spi_rx  (i_spi_rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_MODE;
            ST_MODE:  if (x_ack) state_nx = ST_FETCH;
            ST_FETCH: begin
                if (wi == nw)     state_nx = ST_TERM;
                else if (mem_ack) state_nx = word_bad ? ST_ERR : ST_SEND;
            end
            ST_SEND:  if (x_ack && last_byte) state_nx = ST_STAT;
            ST_STAT:  if (x_ack) state_nx = stat_ok ? ST_FETCH : ST_ERR;
            ST_TERM:  if (x_ack && last_byte) state_nx = ST_FIN;
            ST_FIN:   state_nx = ST_IDLE;
            ST_ERR:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        o_mem_cyc = 1'b0;
        o_mem_adr = 32'h0;
        go        = 1'b0;
        tx        = DUMMY_BYTE;
        unique case (state)
            ST_IDLE: ;
            ST_MODE: begin
                busy = 1'b1;
                go   = ready;
                tx   = MODE_WR;
            end
            ST_FETCH: begin
                busy      = 1'b1;
                o_mem_cyc = (wi != nw);
                o_mem_adr = BASE_ADR + {14'b0, wi, 2'b00};
            end
            ST_SEND: begin
                busy = 1'b1;
                go   = ready;
                tx   = word_byte(word, bc);
            end
            ST_STAT: begin
                busy = 1'b1;
                go   = ready;
            end
            ST_TERM: begin
                busy = 1'b1;
                go   = ready;
                tx   = TERM_BYTE;
            end
            ST_FIN: done = 1'b1;
            ST_ERR: ;
        endcase
    end

    // Datapath: word index, latched count, fetched word, byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wi   <= 16'h0;
            nw   <= 16'h0;
            word <= 32'h0;
            bc   <= 2'd0;
            err  <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                nw  <= n_words;
                wi  <= 16'h0;
                bc  <= 2'd0;
                err <= 1'b0;
            end
            if (mem_ack) word <= i_mem_dat;
            if (x_ack && (state == ST_SEND || state == ST_TERM))
                bc <= bc + 2'd1;
            if (x_ack && state == ST_STAT && stat_ok)
                wi <= wi + 16'd1;
            if (state_nx == ST_ERR) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_boot_loader_tx.sv
// Directed bench for boot_loader_tx with SPI target and source
// memory models.
module tb_boot_loader_tx;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] n_words = 16'h0;
    logic        busy, done, err;
    logic        o_mem_cyc, i_mem_ack;
    logic [31:0] o_mem_adr, i_mem_dat;
    logic        o_spi_req, i_spi_ack;
    logic [7:0]  o_spi_tx, i_spi_rx;
    logic        spi_ack_m, spi_ack_x, mem_ack_m, mem_ack_x;

    assign i_spi_ack = spi_ack_m | spi_ack_x;
    assign i_mem_ack = mem_ack_m | mem_ack_x;

    boot_loader_tx #(
        .GAP_CYC  (16),
        .MODE_WR  (8'h02),
        .BASE_ADR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_words   (n_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .o_mem_cyc (o_mem_cyc),
        .o_mem_adr (o_mem_adr),
        .i_mem_dat (i_mem_dat),
        .i_mem_ack (i_mem_ack),
        .o_spi_req (o_spi_req),
        .o_spi_tx  (o_spi_tx),
        .i_spi_ack (i_spi_ack),
        .i_spi_rx  (i_spi_rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_log [64];
    logic [7:0]  rx_tab [64];
    logic [31:0] mem    [16];
    logic [7:0]  tx_hold;
    logic [31:0] off;
    int nx, done_cnt, overlap, mem_seen, hold_viol;
    int cyc_n, min_sp, last_rise, s_cnt, m_cnt;
    bit s_arm, m_arm, prev_req, spi_rnd, mem_rnd, spur_en;

    // SPI target, source memory and protocol monitors
    initial begin
        spi_ack_m = 0; spi_ack_x = 0; mem_ack_m = 0; mem_ack_x = 0;
        i_spi_rx = 0; i_mem_dat = 0; cyc_n = 0;
        s_arm = 0; m_arm = 0; prev_req = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (rst) begin
                spi_ack_m = 0; mem_ack_m = 0; spi_ack_x = 0; mem_ack_x = 0;
                s_arm = 0; m_arm = 0; prev_req = 0;
            end else begin
                if (o_spi_req && o_mem_cyc) overlap++;
                if (o_mem_cyc) mem_seen++;
                if (done) done_cnt++;
                if (o_spi_req && !prev_req) begin
                    if (last_rise >= 0 && cyc_n - last_rise < min_sp)
                        min_sp = cyc_n - last_rise;
                    last_rise = cyc_n;
                end
                prev_req = o_spi_req;
                if (s_arm && (!o_spi_req || o_spi_tx !== tx_hold)) hold_viol++;
                if (m_arm && !o_mem_cyc) hold_viol++;
                if (spi_ack_m) spi_ack_m = 0;
                else if (o_spi_req) begin
                    if (!s_arm) begin
                        s_arm = 1; tx_hold = o_spi_tx;
                        s_cnt = spi_rnd ? int'($urandom_range(1, 50)) : 1;
                    end
                    s_cnt--;
                    if (s_cnt == 0) begin
                        spi_ack_m = 1; s_arm = 0;
                        i_spi_rx = rx_tab[nx[5:0]];
                        if (nx < 64) tx_log[nx] = o_spi_tx;
                        nx++;
                    end
                end
                if (mem_ack_m) mem_ack_m = 0;
                else if (o_mem_cyc) begin
                    if (!m_arm) begin
                        m_arm = 1;
                        m_cnt = mem_rnd ? int'($urandom_range(0, 5)) : 0;
                    end
                    if (m_cnt == 0) begin
                        off = o_mem_adr - BASE;
                        i_mem_dat = mem[off[5:2]];
                        mem_ack_m = 1; m_arm = 0;
                    end else m_cnt--;
                end
                spi_ack_x = spur_en && !o_spi_req && ($urandom_range(0, 3) == 0);
                mem_ack_x = spur_en && !o_mem_cyc && ($urandom_range(0, 3) == 0);
            end
        end
    end

    task automatic clear_logs();
        nx = 0; done_cnt = 0; overlap = 0; mem_seen = 0; hold_viol = 0;
        min_sp = 1000; last_rise = -1;
        for (int i = 0; i < 64; i++) begin
            rx_tab[i] = 8'h00; tx_log[i] = 8'hxx;
        end
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    endtask

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1; n_words = n;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, o_mem_cyc, o_spi_req} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {busy, done, err, o_mem_cyc, o_spi_req});
        end
        checks++;
        if (o_mem_adr !== 32'h0) begin
            failures++; $display("FAIL reset_adr got=%h want=0", o_mem_adr);
        end
        checks++;
        if (o_spi_tx !== 8'h0) begin
            failures++; $display("FAIL reset_tx got=%h want=0", o_spi_tx);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_three_words(input bit rnd);
        logic [7:0] e[$];
        bit ok;
        clear_logs();
        spi_rnd = rnd; mem_rnd = rnd; spur_en = rnd;
        mem[0] = 32'h11223344; mem[1] = 32'hA5A5A5A5; mem[2] = 32'h00000013;
        rx_tab[10] = 8'h01; rx_tab[15] = 8'h02;
        e = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00,
              8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_start(16'd3);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL w3_busy rnd=%0d got=%b want=1", rnd, busy);
        end
        wait_idle(8000, ok);
        spi_rnd = 0; mem_rnd = 0; spur_en = 0;
        checks++;
        if (!ok) begin failures++; $display("FAIL w3_timeout rnd=%0d", rnd); end
        checks++;
        if (nx != e.size()) begin
            failures++; $display("FAIL w3_count rnd=%0d got=%0d want=%0d", rnd, nx, e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (tx_log[i] !== e[i]) begin
                failures++;
                $display("FAIL w3_byte%0d rnd=%0d got=%h want=%h", i, rnd, tx_log[i], e[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            failures++; $display("FAIL w3_done rnd=%0d done=%0d err=%b want 1/0", rnd, done_cnt, err);
        end
        checks++;
        if (overlap != 0 || hold_viol != 0) begin
            failures++;
            $display("FAIL w3_proto rnd=%0d overlap=%0d hold=%0d want 0/0", rnd, overlap, hold_viol);
        end
        checks++;
        if (min_sp < 18) begin
            failures++; $display("FAIL w3_spacing rnd=%0d got=%0d want>=18", rnd, min_sp);
        end
    endtask

    task automatic test_zero_words();
        logic [7:0] e[$];
        bit ok;
        clear_logs();
        e = '{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_start(16'd0);
        wait_idle(3000, ok);
        checks++;
        if (!ok || nx != 5) begin
            failures++; $display("FAIL w0_count ok=%b got=%0d want=5", ok, nx);
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (tx_log[i] !== e[i]) begin
                failures++; $display("FAIL w0_byte%0d got=%h want=%h", i, tx_log[i], e[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || err !== 1'b0 || mem_seen != 0) begin
            failures++;
            $display("FAIL w0_done done=%0d err=%b memcyc=%0d want 1/0/0", done_cnt, err, mem_seen);
        end
    endtask

    task automatic test_status_error();
        logic [7:0] e[$];
        bit ok;
        clear_logs();
        mem[0] = 32'h11223344; mem[1] = 32'h55667788;
        rx_tab[10] = 8'h05;
        e = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00,
              8'h88, 8'h77, 8'h66, 8'h55, 8'h00};
        do_start(16'd2);
        wait_idle(3000, ok);
        checks++;
        if (!ok || nx != e.size()) begin
            failures++; $display("FAIL st_count ok=%b got=%0d want=%0d", ok, nx, e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (tx_log[i] !== e[i]) begin
                failures++; $display("FAIL st_byte%0d got=%h want=%h", i, tx_log[i], e[i]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done_cnt != 0 || busy !== 1'b0 || nx != e.size()) begin
            failures++;
            $display("FAIL st_err err=%b done=%0d busy=%b n=%0d want 1/0/0/11",
                     err, done_cnt, busy, nx);
        end
    endtask

    task automatic test_end_marker();
        bit ok;
        clear_logs();
        mem[0] = 32'h11223344; mem[1] = 32'hFFFFFFFF; mem[2] = 32'h0000_0001;
        do_start(16'd3);
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL em_errclr got=%b want=0", err);
        end
        wait_idle(3000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || nx != 6 || tx_log[5] !== 8'h00) begin
            failures++; $display("FAIL em_count ok=%b got=%0d want=6", ok, nx);
        end
        checks++;
        if (err !== 1'b1 || done_cnt != 0) begin
            failures++; $display("FAIL em_err err=%b done=%0d want 1/0", err, done_cnt);
        end
    endtask

    task automatic test_abort_restart();
        logic [7:0] e[$];
        bit ok;
        clear_logs();
        mem[0] = 32'h11223344; mem[1] = 32'hA5A5A5A5; mem[2] = 32'h00000013;
        do_start(16'd3);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (nx == 6 && o_spi_req) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL ab_reach timeout n=%0d", nx); end
        #2 rst = 1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, o_mem_cyc, o_spi_req} !== 5'b0 ||
            o_mem_adr !== 32'h0 || o_spi_tx !== 8'h0) begin
            failures++;
            $display("FAIL ab_reset flags=%b adr=%h tx=%h want 0",
                     {busy, done, err, o_mem_cyc, o_spi_req}, o_mem_adr, o_spi_tx);
        end
        @(negedge clk);
        rst = 0;
        clear_logs();
        mem[0] = 32'h11223344; mem[1] = 32'hA5A5A5A5;
        e = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_start(16'd1);
        repeat (40) @(negedge clk);
        start = 1; n_words = 16'd3;
        @(negedge clk);
        start = 0;
        wait_idle(3000, ok);
        checks++;
        if (!ok || nx != e.size()) begin
            failures++; $display("FAIL ab_count ok=%b got=%0d want=%0d", ok, nx, e.size());
        end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (tx_log[i] !== e[i]) begin
                failures++; $display("FAIL ab_byte%0d got=%h want=%h", i, tx_log[i], e[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            failures++; $display("FAIL ab_done done=%0d err=%b want 1/0", done_cnt, err);
        end
    endtask

    initial begin
        spi_rnd = 0; mem_rnd = 0; spur_en = 0;
        clear_logs();
        test_reset();
        test_three_words(1'b0);
        test_zero_words();
        test_status_error();
        test_end_marker();
        test_three_words(1'b1);
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
